// File: rtl/vending_machine.sv
// Coin-operated vending controller for six items: latches a selection, accumulates
// coin credit, then dispenses with change or refunds the full credit on cancel.
module vending_machine (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] coin,
   input  logic [2:0] item,
   input  logic       cancel,
   output logic [2:0] dispense,
   output logic [4:0] change,
   output logic [1:0] state,
   output logic [4:0] total
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COLLECT  = 2'b01,
      DISPENSE = 2'b10,
      RETURN   = 2'b11
   } state_t;

   state_t     state_r;
   logic [4:0] total_r;
   logic [2:0] dispense_r;
   logic [4:0] change_r;
   logic [2:0] item_r;

   logic [2:0] sel_s;
   logic [4:0] price_s;
   logic [4:0] coin_val_s;
   logic [4:0] sum_s;

   function automatic logic [4:0] coin_value(input logic [2:0] c);
      case (c)
         3'b001:  coin_value = 5'd1;
         3'b010:  coin_value = 5'd2;
         3'b011:  coin_value = 5'd5;
         3'b100:  coin_value = 5'd10;
         default: coin_value = 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] item_price(input logic [2:0] i);
      case (i)
         3'b001:  item_price = 5'd3;
         3'b010:  item_price = 5'd5;
         3'b011:  item_price = 5'd8;
         3'b100:  item_price = 5'd10;
         3'b101:  item_price = 5'd18;
         3'b110:  item_price = 5'd20;
         default: item_price = 5'd0;
      endcase
   endfunction

   function automatic logic item_valid(input logic [2:0] i);
      item_valid = (i != 3'b000) && (i != 3'b111);
   endfunction

   // Effective selection (still changeable until the first coin) and the credit after this cycle's coin.
   always_comb begin
      sel_s      = item_r;
      if (total_r == 5'd0) begin
         sel_s = item;
      end else begin
         sel_s = item_r;
      end
      price_s    = item_price(sel_s);
      coin_val_s = coin_value(coin);
      sum_s      = total_r + coin_val_s;
   end

   // Transaction FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         total_r    <= 5'd0;
         dispense_r <= 3'b000;
         change_r   <= 5'd0;
         item_r     <= 3'b000;
      end else begin
         case (state_r)
            IDLE: begin
               total_r    <= 5'd0;
               dispense_r <= 3'b000;
               change_r   <= 5'd0;
               if (item_valid(item)) begin
                  item_r  <= item;
                  state_r <= COLLECT;
               end else begin
                  state_r <= IDLE;
               end
            end
            COLLECT: begin
               if ((total_r == 5'd0) && !item_valid(item)) begin
                  state_r    <= IDLE;
                  item_r     <= 3'b000;
                  total_r    <= 5'd0;
                  dispense_r <= 3'b000;
                  change_r   <= 5'd0;
               end else begin
                  item_r <= sel_s;
                  // Cancel wins over a coin in the same cycle; that coin is dropped.
                  if (cancel) begin
                     state_r    <= RETURN;
                     change_r   <= total_r;
                     dispense_r <= 3'b000;
                  end else if (coin_val_s != 5'd0) begin
                     total_r <= sum_s;
                     if (sum_s >= price_s) begin
                        state_r    <= DISPENSE;
                        dispense_r <= sel_s;
                        change_r   <= sum_s - price_s;
                     end else begin
                        state_r <= COLLECT;
                     end
                  end else begin
                     state_r <= COLLECT;
                  end
               end
            end
            DISPENSE, RETURN: begin
               state_r    <= IDLE;
               total_r    <= 5'd0;
               dispense_r <= 3'b000;
               change_r   <= 5'd0;
            end
            default: begin
               state_r    <= IDLE;
               total_r    <= 5'd0;
               dispense_r <= 3'b000;
               change_r   <= 5'd0;
               item_r     <= 3'b000;
            end
         endcase
      end
   end

   assign state    = state_r;
   assign total    = total_r;
   assign dispense = dispense_r;
   assign change   = change_r;

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine; expected values are hand-computed.
module tb_vending_machine;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] coin;
   logic [2:0] item;
   logic       cancel;
   logic [2:0] dispense;
   logic [4:0] change;
   logic [1:0] state;
   logic [4:0] total;

   int tests  = 0;
   int failed = 0;

   vending_machine dut (
      .clk      (clk),
      .rst      (rst),
      .coin     (coin),
      .item     (item),
      .cancel   (cancel),
      .dispense (dispense),
      .change   (change),
      .state    (state),
      .total    (total)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] st, input logic [4:0] tot,
                          input logic [2:0] disp, input logic [4:0] chg);
      chk({tag, ".state"},    {6'd0, state},    {6'd0, st});
      chk({tag, ".total"},    {3'd0, total},    {3'd0, tot});
      chk({tag, ".dispense"}, {5'd0, dispense}, {5'd0, disp});
      chk({tag, ".change"},   {3'd0, change},   {3'd0, chg});
   endtask

   initial begin
      // Reset for two cycles with random inputs
      rst = 1'b1;
      coin = 3'($urandom_range(0, 7)); item = 3'($urandom_range(0, 7)); cancel = 1'($urandom_range(0, 1));
      step();
      coin = 3'($urandom_range(0, 7)); item = 3'($urandom_range(0, 7)); cancel = 1'($urandom_range(0, 1));
      step();
      chk_all("reset", 2'b00, 5'd0, 3'b000, 5'd0);
      rst = 1'b0; coin = 3'b000; item = 3'b000; cancel = 1'b0;

      // Coins in IDLE are not credited
      coin = 3'b100; step();
      chk_all("idle_coin", 2'b00, 5'd0, 3'b000, 5'd0);
      coin = 3'b000;

      // TOFFEE, one Rs10 coin
      item = 3'b001; step();
      chk_all("toffee_sel", 2'b01, 5'd0, 3'b000, 5'd0);
      coin = 3'b100; step();
      chk_all("toffee_disp", 2'b10, 5'd10, 3'b001, 5'd7);
      item = 3'b000; coin = 3'b000; step();
      chk_all("toffee_idle", 2'b00, 5'd0, 3'b000, 5'd0);

      // CHOCOLATE, Rs2 held three cycles
      item = 3'b010; step();
      chk("choc_sel.state", {6'd0, state}, 8'd1);
      coin = 3'b010; step();
      chk_all("choc_c1", 2'b01, 5'd2, 3'b000, 5'd0);
      item = 3'b000; step();
      chk_all("choc_c2", 2'b01, 5'd4, 3'b000, 5'd0);
      step();
      chk_all("choc_disp", 2'b10, 5'd6, 3'b010, 5'd1);
      coin = 3'b000; step();
      chk_all("choc_idle", 2'b00, 5'd0, 3'b000, 5'd0);

      // CHIPS, exact price
      item = 3'b100; step();
      coin = 3'b011; step();
      chk_all("chips_c1", 2'b01, 5'd5, 3'b000, 5'd0);
      item = 3'b000; step();
      chk_all("chips_disp", 2'b10, 5'd10, 3'b100, 5'd0);
      coin = 3'b000; step();
      chk_all("chips_idle", 2'b00, 5'd0, 3'b000, 5'd0);

      // JUICE, Rs10 + Rs5 then cancel
      item = 3'b101; step();
      coin = 3'b100; step();
      chk("juice_c1.total", {3'd0, total}, 8'd10);
      item = 3'b000; coin = 3'b011; step();
      chk_all("juice_c2", 2'b01, 5'd15, 3'b000, 5'd0);
      coin = 3'b000; cancel = 1'b1; step();
      chk_all("juice_ret", 2'b11, 5'd15, 3'b000, 5'd15);
      cancel = 1'b0; step();
      chk_all("juice_idle", 2'b00, 5'd0, 3'b000, 5'd0);

      // Coin and cancel together: refund is the credit before that coin
      item = 3'b011; step();
      coin = 3'b011; step();
      chk("cc_c1.total", {3'd0, total}, 8'd5);
      item = 3'b000; coin = 3'b010; cancel = 1'b1; step();
      chk_all("cc_ret", 2'b11, 5'd5, 3'b000, 5'd5);
      coin = 3'b000; cancel = 1'b0; step();
      chk_all("cc_idle", 2'b00, 5'd0, 3'b000, 5'd0);

      // Re-select 001 -> 100 before the first coin; CHIPS price applies
      item = 3'b001; step();
      item = 3'b100; step();
      chk_all("resel", 2'b01, 5'd0, 3'b000, 5'd0);
      coin = 3'b011; step();
      chk_all("resel_c1", 2'b01, 5'd5, 3'b000, 5'd0);
      item = 3'b000; step();
      chk_all("resel_disp", 2'b10, 5'd10, 3'b100, 5'd0);
      coin = 3'b000; step();

      // Invalid item in COLLECT with no credit returns to IDLE
      item = 3'b110; step();
      item = 3'b111; step();
      chk_all("desel", 2'b00, 5'd0, 3'b000, 5'd0);
      item = 3'b000;

      // Reset mid-transaction at total = 8 (CHIPS)
      item = 3'b100; step();
      coin = 3'b011; step();
      item = 3'b000; coin = 3'b010; step();
      coin = 3'b001; step();
      chk_all("rst_pre", 2'b01, 5'd8, 3'b000, 5'd0);
      rst = 1'b1; coin = 3'b100; cancel = 1'b1; step();
      chk_all("rst_mid", 2'b00, 5'd0, 3'b000, 5'd0);
      rst = 1'b0; coin = 3'b000; cancel = 1'b0; step();
      chk_all("rst_after", 2'b00, 5'd0, 3'b000, 5'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
